oam_dma: RTL and testbench
==========================

// Module: oam_dma
// PURPOSE
//   Sprite DMA engine on the k6502 CPU bus.
//   - A CPU write to DMA_REG_ADDR latches a source page and halts the CPU via rdy.
//   - The engine then copies XFER_LEN bytes from {page,8'h00} onward to OAM_DATA_ADDR.
//   - It sits beside the CPU. The top level muxes a/d/rw between cpu_* and dma_* using dma_active.
// PARAMETERS
//   DMA_REG_ADDR   16'h4014  CPU write address that triggers a transfer
//   OAM_DATA_ADDR  16'h2004  destination address for every DMA write
//   XFER_LEN       256       bytes per transfer, legal range 1..256
// PORTS
//   clk         in   1   system clock; all state updates on posedge
//   rst         in   1   asynchronous, active-high reset
//   cpu_a       in   16  CPU address bus
//   cpu_dout    in   8   CPU write data
//   cpu_rw      in   1   CPU read/write: 1=read, 0=write
//   bus_din     in   8   read data returned by memory on the shared bus
//   rdy         out  1   to CPU RDY; 0 halts the CPU
//   dma_active  out  1   1 = DMA owns the bus (top-level mux select)
//   dma_a       out  16  DMA address
//   dma_dout    out  8   DMA write data
//   dma_rw      out  1   DMA read/write: 1=read, 0=write
// BEHAVIOUR
//   Reset values: rdy=1, dma_active=0, dma_a=0, dma_dout=0, dma_rw=1.
//     Internal: state=IDLE, phase=0, count=0, page=0, latch=0.
//   phase: 1-bit register, toggles every clk from reset. DMA reads issue only when phase==0.
//   Trigger: in IDLE, a sampled edge with cpu_rw==0 && cpu_a==DMA_REG_ADDR
//     -> page<=cpu_dout, count<=0, state<=HALT.
//   States:
//     IDLE   rdy=1, dma_active=0. Waits for the trigger.
//     HALT   rdy=0, dma_active=0. The CPU finishes any write in flight.
//            Next state is DUMMY on the first edge where cpu_rw==1; otherwise stays in HALT.
//     DUMMY  rdy=0, dma_active=1, dma_rw=1, dma_a=cpu_a held. One cycle.
//            Next state is READ if phase==1, else ALIGN.
//     ALIGN  Same outputs as DUMMY. One cycle. Next state is READ.
//     READ   dma_active=1, dma_rw=1, dma_a={page,count[7:0]}.
//            latch<=bus_din at end of cycle. Next state is WRITE.
//     WRITE  dma_active=1, dma_rw=0, dma_a=OAM_DATA_ADDR, dma_dout=latch.
//            count<=count+1.
//            Next state is IDLE if count==XFER_LEN-1, else READ.
//   In every non-IDLE state rdy=0. rdy returns to 1 on the edge leaving the last WRITE.
//   count is 9 bits wide. The low byte never carries into page: no page crossing.
//   Total halt length from HALT exit to rdy=1 is 2*XFER_LEN+1 or 2*XFER_LEN+2 cycles.
//     XFER_LEN=256 gives 513 or 514 cycles.
//   Outside READ and WRITE: dma_dout holds its last value and dma_rw=1.
//   Triggers are ignored in any state other than IDLE.
//     The DMA's own writes to OAM_DATA_ADDR never retrigger.
//   rst asserted mid-transfer: immediate return to reset values. rdy=1 asynchronously.
//     No partial state is retained.
//   A trigger arriving on the same edge that returns the engine to IDLE is not captured.
// TESTING
//   1 Reset: rst=1 for 2 cycles -> rdy=1, dma_active=0, dma_rw=1.
//   2 Trigger: CPU writes 8'h02 to 16'h4014, memory $0200+i = i^8'hA5, then cpu_rw=1.
//     -> 256 writes to 16'h2004 with data i^8'hA5 in order.
//     -> reads from 16'h0200..16'h02FF.
//     -> rdy low for 513 or 514 cycles.
//   3 Parity: trigger so HALT exits with phase 0, then with phase 1.
//     -> ALIGN present in exactly one case; every READ has phase==0.
//   4 Halt wait: cpu_rw held 0 for 3 cycles after trigger.
//     -> engine stays in HALT, dma_active=0, then proceeds once cpu_rw=1.
//   5 Reset mid-transfer: rst pulse after the 100th WRITE.
//     -> rdy=1 and dma_active=0 immediately.
//     -> a new $4014 write of 8'h03 starts reads at 16'h0300.
//   6 XFER_LEN=4 build, page 8'h07.
//     -> exactly 4 reads at 16'h0700..16'h0703 and 4 writes to 16'h2004.
//     -> then rdy=1; a write to 16'h4015 causes no transfer.

Source files
------------

// File: rtl/oam_dma.sv
// Sprite DMA engine: a CPU write to DMA_REG_ADDR halts the CPU and copies
// XFER_LEN bytes from {page,8'h00} onward into OAM_DATA_ADDR, one read/write pair per byte.
module oam_dma #(
   parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
   parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
   parameter int          XFER_LEN      = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cpu_a,
   input  logic [7:0]  cpu_dout,
   input  logic        cpu_rw,
   input  logic [7:0]  bus_din,
   output logic        rdy,
   output logic        dma_active,
   output logic [15:0] dma_a,
   output logic [7:0]  dma_dout,
   output logic        dma_rw
);

   typedef enum logic [2:0] {IDLE, HALT, DUMMY, ALIGN, READ, WRITE} state_t;

   localparam logic [8:0] LAST = 9'(XFER_LEN - 1);

   state_t      state, state_nxt;
   logic        phase;
   logic [8:0]  count;
   logic [7:0]  page;
   logic [7:0]  latch;
   logic        trig;

   assign trig     = !cpu_rw && (cpu_a == DMA_REG_ADDR);
   assign dma_dout = latch;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         phase <= 1'b0;
         count <= '0;
         page  <= '0;
         latch <= '0;
      end else begin
         state <= state_nxt;
         phase <= ~phase;
         if (state == IDLE && trig) begin
            page  <= cpu_dout;
            count <= '0;
         end
         if (state == READ)
            latch <= bus_din;
         if (state == WRITE)
            count <= count + 9'd1;
      end
   end

   // DUMMY/ALIGN drive the CPU's held address so the bus sees a harmless read.
   always_comb begin
      state_nxt  = state;
      rdy        = 1'b0;
      dma_active = 1'b1;
      dma_rw     = 1'b1;
      dma_a      = cpu_a;
      case (state)
         IDLE: begin
            rdy        = 1'b1;
            dma_active = 1'b0;
            dma_a      = '0;
            if (trig)
               state_nxt = HALT;
         end
         HALT: begin
            dma_active = 1'b0;
            dma_a      = '0;
            if (cpu_rw)
               state_nxt = DUMMY;
         end
         DUMMY: state_nxt = phase ? READ : ALIGN;
         ALIGN: state_nxt = READ;
         READ: begin
            dma_a     = {page, count[7:0]};
            state_nxt = WRITE;
         end
         WRITE: begin
            dma_rw    = 1'b0;
            dma_a     = OAM_DATA_ADDR;
            state_nxt = (count == LAST) ? IDLE : READ;
         end
         default: begin
            rdy        = 1'b1;
            dma_active = 1'b0;
            dma_a      = '0;
            state_nxt  = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: a 256-byte and a 4-byte engine share the CPU bus signals;
// a bus monitor checks every DMA read/write against expectation queues.
module tb_oam_dma;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] cpu_a0, cpu_a1;
   logic [7:0]  cpu_dout;
   logic        cpu_rw;
   logic [7:0]  din0, din1;
   logic        rdy0, rdy1, act0, act1, rw0, rw1;
   logic [15:0] a0, a1;
   logic [7:0]  d0, d1;

   int total = 0;
   int bad   = 0;
   int nrd, nwr, ndummy, nact;
   logic mph;
   logic [15:0] exp_rd[$];
   logic [7:0]  exp_wr[$];

   typedef struct {
      int         which;
      logic [7:0] page;
      int         hold;
      logic       ph;
      int         n;
      int         expd;
   } vec_t;
   vec_t vecs[4];

   always #5 clk = ~clk;

   function automatic logic [7:0] memf(input logic [15:0] a);
      if (a[15:8] == 8'h02)
         return a[7:0] ^ 8'hA5;
      return a[7:0] + a[15:8];
   endfunction

   assign din0 = memf(a0);
   assign din1 = memf(a1);

   oam_dma u0 (
      .clk(clk), .rst(rst), .cpu_a(cpu_a0), .cpu_dout(cpu_dout), .cpu_rw(cpu_rw),
      .bus_din(din0), .rdy(rdy0), .dma_active(act0), .dma_a(a0), .dma_dout(d0), .dma_rw(rw0)
   );

   oam_dma #(.XFER_LEN(4)) u1 (
      .clk(clk), .rst(rst), .cpu_a(cpu_a1), .cpu_dout(cpu_dout), .cpu_rw(cpu_rw),
      .bus_din(din1), .rdy(rdy1), .dma_active(act1), .dma_a(a1), .dma_dout(d1), .dma_rw(rw1)
   );

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, got, want);
      end
   endtask

   // Reference phase: cleared by reset, toggles on every clock edge.
   always @(posedge clk or posedge rst)
      if (rst) mph <= 1'b0;
      else     mph <= ~mph;

   always @(negedge clk) begin
      logic [15:0] ma, mc;
      logic        mrw;
      logic [7:0]  md;
      ma  = act1 ? a1 : a0;
      mc  = act1 ? cpu_a1 : cpu_a0;
      mrw = act1 ? rw1 : rw0;
      md  = act1 ? d1 : d0;
      if (!rst && (act0 || act1)) begin
         nact++;
         if (!mrw) begin
            chk("wr_addr", ma, 16'h2004);
            chk("wr_expected", exp_wr.size() != 0, 1);
            if (exp_wr.size() != 0) chk("wr_data", md, exp_wr.pop_front());
            nwr++;
         end else if (ma == mc) begin
            ndummy++;
         end else begin
            chk("rd_expected", exp_rd.size() != 0, 1);
            if (exp_rd.size() != 0) chk("rd_addr", ma, exp_rd.pop_front());
            chk("rd_phase", mph, 0);
            nrd++;
         end
      end
   end

   task automatic start_xfer(input int which, input logic [7:0] page, input int hold,
                             input logic ph, input int n);
      exp_rd.delete();
      exp_wr.delete();
      nrd = 0; nwr = 0; ndummy = 0; nact = 0;
      for (int i = 0; i < n; i++) begin
         logic [15:0] ad;
         ad = {page, 8'(i)};
         exp_rd.push_back(ad);
         exp_wr.push_back(memf(ad));
      end
      @(negedge clk);
      if (which == 1) cpu_a1 = 16'h4014;
      else            cpu_a0 = 16'h4014;
      cpu_dout = page;
      cpu_rw   = 1'b0;
      @(negedge clk);
      cpu_a0 = 16'h8000;
      cpu_a1 = 16'h8000;
      #1;
      chk("halt_rdy", which == 1 ? rdy1 : rdy0, 0);
      chk("halt_active", which == 1 ? act1 : act0, 0);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk); #1;
         chk("hold_rdy", which == 1 ? rdy1 : rdy0, 0);
         chk("hold_active", which == 1 ? act1 : act0, 0);
      end
      // DUMMY's phase is the complement of the phase seen in the last HALT cycle.
      while (mph == ph) begin
         @(negedge clk); #1;
         chk("hold_active", which == 1 ? act1 : act0, 0);
      end
      cpu_rw = 1'b1;
   endtask

   task automatic finish_xfer(input int which, input logic [7:0] page, input int n, input int expd);
      int t;
      t = 0;
      while ((which == 1 ? rdy1 : rdy0) == 1'b0 && t < 1000) begin
         @(negedge clk); #1;
         t++;
      end
      chk("done_in_time", t < 1000, 1);
      chk("rd_count", nrd, n);
      chk("wr_count", nwr, n);
      chk("dummy_count", ndummy, expd);
      chk("active_cycles", nact, 2 * n + expd);
      chk("queues_empty", exp_rd.size() + exp_wr.size(), 0);
      chk("idle_rw", which == 1 ? rw1 : rw0, 1);
      chk("idle_active", which == 1 ? act1 : act0, 0);
      chk("idle_dout", which == 1 ? d1 : d0, memf({page, 8'(n - 1)}));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      vecs[0] = '{which: 0, page: 8'h02, hold: 0, ph: 1'b1, n: 256, expd: 1};
      vecs[1] = '{which: 1, page: 8'h07, hold: 3, ph: 1'b0, n: 4,   expd: 2};
      vecs[2] = '{which: 1, page: 8'h07, hold: 0, ph: 1'b1, n: 4,   expd: 1};
      vecs[3] = '{which: 0, page: 8'h05, hold: 1, ph: 1'b0, n: 256, expd: 2};

      rst = 1'b1; cpu_a0 = 16'h8000; cpu_a1 = 16'h8000; cpu_dout = 8'h00; cpu_rw = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_rdy", {rdy1, rdy0}, 2'b11);
      chk("rst_active", {act1, act0}, 2'b00);
      chk("rst_rw", {rw1, rw0}, 2'b11);
      chk("rst_addr", a0 | a1, 0);
      chk("rst_dout", d0 | d1, 0);
      rst = 1'b0;
      @(negedge clk); #1;
      chk("post_rst_rdy", {rdy1, rdy0}, 2'b11);
      chk("post_rst_active", {act1, act0}, 2'b00);

      for (int v = 0; v < 4; v++) begin
         start_xfer(vecs[v].which, vecs[v].page, vecs[v].hold, vecs[v].ph, vecs[v].n);
         finish_xfer(vecs[v].which, vecs[v].page, vecs[v].n, vecs[v].expd);
      end

      // A write to the neighbouring register must not start a transfer.
      @(negedge clk);
      cpu_a1 = 16'h4015; cpu_dout = 8'h07; cpu_rw = 1'b0;
      @(negedge clk);
      cpu_a1 = 16'h8000; cpu_rw = 1'b1;
      repeat (4) begin
         @(negedge clk); #1;
         chk("no_trig_rdy", rdy1, 1);
         chk("no_trig_active", act1, 0);
      end

      // Reset in the middle of a transfer, then restart from page 3.
      start_xfer(0, 8'h02, 0, 1'b1, 256);
      t = 0;
      while (nwr < 100 && t < 400) begin
         @(negedge clk); #1;
         t++;
      end
      chk("reached_100_writes", nwr, 100);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("midrst_rdy", rdy0, 1);
      chk("midrst_active", act0, 0);
      chk("midrst_rw", rw0, 1);
      chk("midrst_addr", a0, 0);
      chk("midrst_dout", d0, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      start_xfer(0, 8'h03, 0, 1'b0, 256);
      finish_xfer(0, 8'h03, 256, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
